// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 set-2 scancode decoder: prefix and shift
// codes, the decoder FSM state type and the scancode-to-ASCII lookup.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  // Set-2 make code to ASCII. Unmapped codes return 8'h00. With shift set,
  // letters become uppercase and the digit row yields its shifted symbols.
  function automatic logic [7:0] sc2ascii(input logic [7:0] sc, input logic shift);
    logic [7:0] base;
    logic [7:0] result;
    case (sc)
      8'h16: base = "1";
      8'h1E: base = "2";
      8'h26: base = "3";
      8'h25: base = "4";
      8'h2E: base = "5";
      8'h36: base = "6";
      8'h3D: base = "7";
      8'h3E: base = "8";
      8'h46: base = "9";
      8'h45: base = "0";
      8'h1C: base = "a";
      8'h32: base = "b";
      8'h21: base = "c";
      8'h23: base = "d";
      8'h24: base = "e";
      8'h2B: base = "f";
      8'h34: base = "g";
      8'h33: base = "h";
      8'h43: base = "i";
      8'h3B: base = "j";
      8'h42: base = "k";
      8'h4B: base = "l";
      8'h3A: base = "m";
      8'h31: base = "n";
      8'h44: base = "o";
      8'h4D: base = "p";
      8'h15: base = "q";
      8'h2D: base = "r";
      8'h1B: base = "s";
      8'h2C: base = "t";
      8'h3C: base = "u";
      8'h2A: base = "v";
      8'h1D: base = "w";
      8'h22: base = "x";
      8'h35: base = "y";
      8'h1A: base = "z";
      8'h29: base = 8'h20;
      8'h5A: base = 8'h0D;
      default: base = 8'h00;
    endcase

    result = base;
    if (shift) begin
      if (base >= "a" && base <= "z") begin
        result = base - 8'h20;
      end else begin
        case (base)
          "1": result = "!";
          "2": result = "@";
          "3": result = "#";
          "4": result = "$";
          "5": result = "%";
          "6": result = "^";
          "7": result = "&";
          "8": result = "*";
          "9": result = "(";
          "0": result = ")";
          default: result = base;
        endcase
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ps2_char_fifo.sv
// Synchronous character FIFO. A push while full is accepted only when a pop
// happens in the same cycle. When the FIFO is empty, head keeps showing the
// last character popped.
module ps2_char_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic [WIDTH-1:0] hold;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? hold : mem[rd_ptr];

  // Pointer, level and hold-register bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: non-blocking assignments keep every register reading the values from before this edge.
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      hold   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an entry is only read after it has been written, so a reset would buy nothing.
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode stream to ASCII character stream. Tracks break (F0)
// and extended (E0) prefixes, the held key and a press counter, and queues
// decoded characters in a FIFO with a valid/ready output.
// Optional feature macro: PS2_SHIFT_EN enables shift-key tracking
// (uppercase letters and shifted digit symbols).
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  parameter int REPEAT     = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             sc_valid,
  input  logic [7:0]       sc_data,
  output logic             ch_valid,
  output logic [7:0]       ch_data,
  input  logic             ch_ready,
  output logic             key_held,
  output logic [7:0]       last_scan,
  output logic [7:0]       last_ascii,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf
);

  state_t     state;
  state_t     state_nxt;
  logic       is_make;
  logic       is_ext_make;
  logic       is_break;
  logic       shift_key;
  logic       shift;
  logic       new_key;
  logic       rpt_key;
  logic [7:0] ascii;
  logic       push_req;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;

  // Prefix FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and byte classification; advances only on sc_valid.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    state_nxt   = state;
    is_make     = 1'b0;
    is_ext_make = 1'b0;
    is_break    = 1'b0;
    if (sc_valid) begin
      case (state)
        IDLE: begin
          if (sc_data == SC_EXT)        state_nxt = EXT;
          else if (sc_data == SC_BREAK) state_nxt = BRK;
          else                          is_make   = 1'b1;
        end
        BRK: begin
          is_break  = 1'b1;
          state_nxt = IDLE;
        end
        EXT: begin
          if (sc_data == SC_BREAK) begin
            state_nxt = EXT_BRK;
          end else begin
            is_ext_make = 1'b1;
            state_nxt   = IDLE;
          end
        end
        EXT_BRK: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef PS2_SHIFT_EN
  assign shift_key = (sc_data == SC_LSHIFT) || (sc_data == SC_RSHIFT);

  // Shift state: set by a shift make, cleared by a shift break.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                       shift <= 1'b0;
    else if (is_make && shift_key)     shift <= 1'b1;
    else if (is_break && shift_key)    shift <= 1'b0;
  end
`else
  assign shift_key = 1'b0;
  assign shift     = 1'b0;
`endif

  // A make is a new press unless it repeats the key already held.
  assign new_key  = is_make && !shift_key && (!key_held || (sc_data != last_scan));
  assign rpt_key  = is_make && !shift_key && !new_key;
  assign ascii    = sc2ascii(sc_data, shift);
  assign push_req = (new_key || (rpt_key && (REPEAT != 0))) && (ascii != 8'h00);
  assign pop      = ch_valid && ch_ready;
  assign ch_valid = !fifo_empty;

  // Held-key tracking and last decoded make.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_held   <= 1'b0;
      last_scan  <= '0;
      last_ascii <= '0;
    end else if (new_key) begin
      key_held   <= 1'b1;
      last_scan  <= sc_data;
      last_ascii <= ascii;
    end else if (is_break && (sc_data == last_scan)) begin
      key_held   <= 1'b0;
    end
  end

  // Press counter: new non-extended presses and extended makes; wraps.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                     press_cnt <= '0;
    else if (new_key || is_ext_make) press_cnt <= press_cnt + 1'b1;
  end

  // Sticky overflow: a push found the FIFO full with no pop to make room.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                             ovf <= 1'b0;
    else if (push_req && fifo_full && !pop)  ovf <= 1'b1;
  end

  ps2_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_req),
    .din    (ascii),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (ch_data)
  );

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder. A REPEAT=0 instance is the main
// target; a REPEAT=1 instance shares the inputs and is checked only in the
// typematic-repeat step. Build with +define+PS2_SHIFT_EN to check shift.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       sc_valid = 1'b0;
  logic [7:0] sc_data = 8'h00;
  logic       ch_ready = 1'b0;

  logic       ch_valid, key_held, ovf;
  logic [7:0] ch_data, last_scan, last_ascii, press_cnt;

  logic       r_ch_valid, r_key_held, r_ovf;
  logic [7:0] r_ch_data, r_last_scan, r_last_ascii, r_press_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.FIFO_DEPTH(8), .CNT_W(8), .REPEAT(0)) u_dut (
    .clk(clk), .resetn(resetn), .sc_valid(sc_valid), .sc_data(sc_data),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .key_held(key_held), .last_scan(last_scan), .last_ascii(last_ascii),
    .press_cnt(press_cnt), .ovf(ovf)
  );

  ps2_scancode_decoder #(.FIFO_DEPTH(8), .CNT_W(8), .REPEAT(1)) u_rpt (
    .clk(clk), .resetn(resetn), .sc_valid(sc_valid), .sc_data(sc_data),
    .ch_valid(r_ch_valid), .ch_data(r_ch_data), .ch_ready(ch_ready),
    .key_held(r_key_held), .last_scan(r_last_scan), .last_ascii(r_last_ascii),
    .press_cnt(r_press_cnt), .ovf(r_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    sc_valid = 1'b0;
    ch_ready = 1'b0;
    resetn   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn   = 1'b1;
  endtask

  // One scancode strobe; returns on the following falling edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    sc_valid = 1'b1;
    sc_data  = b;
    @(negedge clk);
    sc_valid = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    ch_ready = 1'b1;
    @(negedge clk);
    ch_ready = 1'b0;
  endtask

  // Checks the main instance's head, then pops it.
  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, ch_valid, 1);
    check({tag, "_data"}, ch_data, exp);
    pop_one();
  endtask

  initial begin
    logic [7:0] digits [8];
    digits = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};

    // Reset state.
    do_reset();
    check("rst_ch_valid", ch_valid, 0);
    check("rst_ch_data", ch_data, 0);
    check("rst_key_held", key_held, 0);
    check("rst_last_scan", last_scan, 0);
    check("rst_last_ascii", last_ascii, 0);
    check("rst_press_cnt", press_cnt, 0);
    check("rst_ovf", ovf, 0);

    // Make / break of 'a'.
    send(8'h1C);
    check("mk_ch_valid", ch_valid, 1);
    check("mk_ch_data", ch_data, 8'h61);
    check("mk_key_held", key_held, 1);
    check("mk_last_scan", last_scan, 8'h1C);
    check("mk_last_ascii", last_ascii, 8'h61);
    check("mk_press_cnt", press_cnt, 1);
    send(8'hF0);
    check("f0_key_held", key_held, 1);
    send(8'h1C);
    check("brk_key_held", key_held, 0);
    check("brk_press_cnt", press_cnt, 1);
    pop_check("brk_pop", 8'h61);
    check("empty_ch_valid", ch_valid, 0);
    check("empty_hold_data", ch_data, 8'h61);
    pop_one();
    check("empty_pop_ignored", ch_valid, 0);

    // Typematic repeat: REPEAT=0 pushes once, REPEAT=1 pushes three times.
    do_reset();
    send(8'h1C);
    send(8'h1C);
    send(8'h1C);
    check("rpt0_press_cnt", press_cnt, 1);
    check("rpt1_press_cnt", r_press_cnt, 1);
    check("rpt1_last_scan", r_last_scan, 8'h1C);
    check("rpt1_pop1_data", r_ch_data, 8'h61);
    pop_check("rpt0_pop1", 8'h61);
    check("rpt0_empty", ch_valid, 0);
    check("rpt1_pop2_valid", r_ch_valid, 1);
    check("rpt1_pop2_data", r_ch_data, 8'h61);
    pop_one();
    check("rpt1_pop3_valid", r_ch_valid, 1);
    check("rpt1_pop3_data", r_ch_data, 8'h61);
    pop_one();
    check("rpt1_empty", r_ch_valid, 0);

    // Extended make and break.
    do_reset();
    send(8'hE0);
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check("ext_ch_valid", ch_valid, 0);
    check("ext_press_cnt", press_cnt, 1);
    check("ext_key_held", key_held, 0);
    check("ext_last_scan", last_scan, 0);
    send(8'h1C);
    check("ext_idle_ch_data", ch_data, 8'h61);
    check("ext_idle_last_scan", last_scan, 8'h1C);
    check("ext_idle_press_cnt", press_cnt, 2);

    // Fill, overflow, then push while full with a simultaneous pop.
    do_reset();
    for (int i = 0; i < 8; i++) send(digits[i]);
    check("fill_ovf", ovf, 0);
    send(8'h46);
    check("ovf_set", ovf, 1);
    check("ovf_press_cnt", press_cnt, 9);
    check("ovf_head", ch_data, 8'h31);
    @(negedge clk);
    sc_valid = 1'b1;
    sc_data  = 8'h45;
    ch_ready = 1'b1;
    @(negedge clk);
    sc_valid = 1'b0;
    ch_ready = 1'b0;
    check("full_pop_push_ovf", ovf, 1);
    for (int i = 0; i < 7; i++) pop_check($sformatf("ovf_pop%0d", i), 8'h32 + 8'(i));
    pop_check("ovf_pop_last", 8'h30);
    check("ovf_drained", ch_valid, 0);
    check("ovf_sticky", ovf, 1);

    // Shift handling.
    do_reset();
    send(8'h12);
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    send(8'hF0);
    send(8'h12);
    send(8'h1C);
`ifdef PS2_SHIFT_EN
    check("shift_press_cnt", press_cnt, 2);
    pop_check("shift_pop_upper", 8'h41);
`else
    check("noshift_press_cnt", press_cnt, 3);
    pop_check("noshift_pop1", 8'h61);
`endif
    pop_check("shift_pop_lower", 8'h61);
    check("shift_empty", ch_valid, 0);

    // Reset after a break prefix discards the prefix.
    do_reset();
    send(8'hF0);
    do_reset();
    send(8'h16);
    check("midrst_press_cnt", press_cnt, 1);
    check("midrst_last_scan", last_scan, 8'h16);
    pop_check("midrst_pop", 8'h31);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
